button_bank_ctrl: RTL and testbench

- Multi-channel successor to the single-button debouncer used by the fan control front panel.
- Per channel it provides:
  - 2-FF input synchroniser.
  - Restart-on-bounce debounce in both directions.
  - Debounced level output.
  - Single-cycle press, release and short-click pulses.
  - Long-press detection and an optional auto-repeat pulse train.
- Sits between the board push-buttons and the fan-speed / mode FSM.

---
 rtl/button_pkg.sv | 47 ++++
 rtl/button_channel.sv | 222 ++++++++++++++++++++++
 rtl/button_bank_ctrl.sv | 66 ++++++
 tb/tb_button_bank_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Purpose : shared FSM encodings and parameter legality helpers for the button bank.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ST_IDLE/ST_DEB_P/ST_HELD/ST_DEB_R - per-channel FSM state codes (2 bits).
//   max3()      - largest of three counts, used to size-check the counters.
//   params_ok() - elaboration-time legality check of the bank parameter set.

package button_pkg;

   localparam int ST_W = 2;

   // Released, debouncing a press, pressed, debouncing a release.
   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_DEB_P = 2'd1;
   localparam logic [ST_W-1:0] ST_HELD  = 2'd2;
   localparam logic [ST_W-1:0] ST_DEB_R = 2'd3;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // The counters must be able to hold the largest programmed count without
   // wrapping, the long-press window has to outlast the debounce window, and
   // every count must be at least one cycle.
   function automatic bit params_ok(input int n_btn,
                                    input int deb,
                                    input int long_press,
                                    input int rep,
                                    input int cnt_w);
      bit    ok;
      longint lim;
      ok = (n_btn >= 1) && (deb >= 1) && (long_press > deb) &&
           (rep >= 1) && (cnt_w >= 1) && (cnt_w <= 62);
      if (ok) begin
         lim = longint'(1) << cnt_w;
         ok  = longint'(max3(deb, long_press, rep)) < lim;
      end
      return ok;
   endfunction

endpackage

// File: rtl/button_channel.sv
// Purpose : one push-button channel: 2-FF synchroniser, restart-on-bounce
//           debounce both ways, level / press / release / click / long / repeat.
// Latency : level and press/release pulses DEBOUNCE+2 cycles after a clean pin edge;
//           no backpressure, every output is a registered level or 1-cycle pulse.
//
// Ports:
//   i_clk, i_reset       clock and asynchronous active-high reset
//   i_button             raw asynchronous pin
//   o_level              debounced pushed level
//   o_press / o_release  1-cycle pulses on accepted press / release
//   o_click              1-cycle pulse on release when no long press fired
//   o_long               1-cycle pulse LONG_PRESS cycles after o_press
//   o_repeat             1-cycle pulses every REPEAT cycles after o_long

module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE   = 1_000_000,
   parameter int LONG_PRESS = 50_000_000,
   parameter int REPEAT     = 10_000_000,
   parameter int REPEAT_EN  = 1,
   parameter int ACTIVE_LOW = 0,
   parameter int CNT_W      = 32
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_button,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_click,
   output logic o_long,
   output logic o_repeat
);

   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_C  = '0;
   localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_PRESS - 1);
   localparam logic [CNT_W-1:0] REP_C   = CNT_W'(REPEAT - 1);
   localparam logic             INV_C   = (ACTIVE_LOW != 0);
   localparam logic             REPEN_C = (REPEAT_EN != 0);

   // ---------------------------------------------------------------
   // Synchroniser. Inversion happens before the first flop so that the
   // reset value 0 always means "released" whatever the pin polarity.
   // ---------------------------------------------------------------
   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= i_button ^ INV_C;
         sync2_q <= sync1_q;
      end
   end

   logic s;
   assign s = sync2_q;

   // ---------------------------------------------------------------
   // FSM and counters
   // ---------------------------------------------------------------
   logic [ST_W-1:0]  state_q,     state_d;
   logic [CNT_W-1:0] dcnt_q,      dcnt_d;
   logic [CNT_W-1:0] hcnt_q,      hcnt_d;
   logic             long_flag_q, long_flag_d;
   logic             level_q,     level_d;
   logic             press_q,     press_d;
   logic             release_q,   release_d;
   logic             click_q,     click_d;
   logic             long_q,      long_d;
   logic             repeat_q,    repeat_d;

   // dcnt is zero in IDLE and HELD, so dcnt_q+1 is also the "first stable
   // sample" count when a new edge is seen there. A change is accepted on
   // the cycle that samples the DEBOUNCE-th consecutive stable value.
   logic [CNT_W-1:0] dcnt_inc;
   logic             deb_done;

   assign dcnt_inc = dcnt_q + ONE_C;
   assign deb_done = (dcnt_inc == DEB_C);

   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      long_flag_d = long_flag_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      click_d     = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s) begin
               if (deb_done) begin
                  state_d     = ST_HELD;
                  dcnt_d      = ZERO_C;
                  hcnt_d      = ZERO_C;
                  long_flag_d = 1'b0;
                  level_d     = 1'b1;
                  press_d     = 1'b1;
               end else begin
                  state_d = ST_DEB_P;
                  dcnt_d  = dcnt_inc;
               end
            end
         end

         ST_DEB_P: begin
            if (!s) begin
               // Bounce: throw away the partial count and start over.
               state_d = ST_IDLE;
               dcnt_d  = ZERO_C;
            end else if (deb_done) begin
               state_d     = ST_HELD;
               dcnt_d      = ZERO_C;
               hcnt_d      = ZERO_C;
               long_flag_d = 1'b0;
               level_d     = 1'b1;
               press_d     = 1'b1;
            end else begin
               dcnt_d = dcnt_inc;
            end
         end

         ST_HELD: begin
            if (!s) begin
               // hcnt is left alone so a release bounce resumes the hold timing.
               if (deb_done) begin
                  state_d   = ST_IDLE;
                  dcnt_d    = ZERO_C;
                  level_d   = 1'b0;
                  release_d = 1'b1;
                  click_d   = ~long_flag_q;
               end else begin
                  state_d = ST_DEB_R;
                  dcnt_d  = dcnt_inc;
               end
            end else if (!long_flag_q) begin
               if (hcnt_q == LONG_C) begin
                  long_d      = 1'b1;
                  long_flag_d = 1'b1;
                  hcnt_d      = ZERO_C;
               end else begin
                  hcnt_d = hcnt_q + ONE_C;
               end
            end else if (REPEN_C) begin
               if (hcnt_q == REP_C) begin
                  repeat_d = 1'b1;
                  hcnt_d   = ZERO_C;
               end else begin
                  hcnt_d = hcnt_q + ONE_C;
               end
            end
            // With repeat disabled and the long press already reported there
            // is nothing left to time, so hcnt parks instead of wrapping.
         end

         ST_DEB_R: begin
            if (s) begin
               state_d = ST_HELD;
               dcnt_d  = ZERO_C;
            end else if (deb_done) begin
               state_d   = ST_IDLE;
               dcnt_d    = ZERO_C;
               level_d   = 1'b0;
               release_d = 1'b1;
               click_d   = ~long_flag_q;
            end else begin
               dcnt_d = dcnt_inc;
            end
         end

         default: begin
            state_d = ST_IDLE;
            dcnt_d  = ZERO_C;
            level_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         dcnt_q      <= '0;
         hcnt_q      <= '0;
         long_flag_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         click_q     <= 1'b0;
         long_q      <= 1'b0;
         repeat_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         hcnt_q      <= hcnt_d;
         long_flag_q <= long_flag_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         click_q     <= click_d;
         long_q      <= long_d;
         repeat_q    <= repeat_d;
      end
   end

   assign o_level   = level_q;
   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_click   = click_q;
   assign o_long    = long_q;
   assign o_repeat  = repeat_q;

endmodule

// File: rtl/button_bank_ctrl.sv
// Purpose : bank of N_BTN independent debounced push-button channels for the
//           fan front panel. Latency: DEBOUNCE+2 cycles pin edge to press/release.
// Backpressure: none; all outputs are registered levels or 1-cycle pulses.
//
// Ports (bit k of every vector belongs to channel k):
//   i_clk, i_reset   clock and asynchronous active-high reset
//   i_button         raw asynchronous button pins
//   o_level          debounced pushed level
//   o_press          1-cycle pulse on accepted press
//   o_release        1-cycle pulse on accepted release
//   o_click          1-cycle pulse on release of a press that never went long
//   o_long           1-cycle pulse LONG_PRESS cycles after o_press
//   o_repeat         1-cycle pulse train, REPEAT apart, after o_long

module button_bank_ctrl
   import button_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int DEBOUNCE   = 1_000_000,
   parameter int LONG_PRESS = 50_000_000,
   parameter int REPEAT     = 10_000_000,
   parameter int REPEAT_EN  = 1,
   parameter int ACTIVE_LOW = 0,
   parameter int CNT_W      = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [N_BTN-1:0] i_button,
   output logic [N_BTN-1:0] o_level,
   output logic [N_BTN-1:0] o_press,
   output logic [N_BTN-1:0] o_release,
   output logic [N_BTN-1:0] o_click,
   output logic [N_BTN-1:0] o_long,
   output logic [N_BTN-1:0] o_repeat
);

   // Refuse to elaborate a parameter set whose counters could wrap or whose
   // long-press window is shorter than the debounce window.
   if (!params_ok(N_BTN, DEBOUNCE, LONG_PRESS, REPEAT, CNT_W)) begin : g_bad_params
      $error("button_bank_ctrl: illegal DEBOUNCE/LONG_PRESS/REPEAT/CNT_W combination");
   end

   // Channels share nothing but clock and reset; simultaneous presses give
   // simultaneous pulses on their own bits.
   for (genvar k = 0; k < N_BTN; k++) begin : g_ch
      button_channel #(
         .DEBOUNCE   (DEBOUNCE),
         .LONG_PRESS (LONG_PRESS),
         .REPEAT     (REPEAT),
         .REPEAT_EN  (REPEAT_EN),
         .ACTIVE_LOW (ACTIVE_LOW),
         .CNT_W      (CNT_W)
      ) u_ch (
         .i_clk     (i_clk),
         .i_reset   (i_reset),
         .i_button  (i_button[k]),
         .o_level   (o_level[k]),
         .o_press   (o_press[k]),
         .o_release (o_release[k]),
         .o_click   (o_click[k]),
         .o_long    (o_long[k]),
         .o_repeat  (o_repeat[k])
      );
   end

endmodule

// File: tb/tb_button_bank_ctrl.sv
// Purpose : directed bench for button_bank_ctrl: three instances (repeat on,
//           repeat off, active-low pins) sharing clock and reset.
// Pulses are counted and time-stamped by cycle number after every clock edge.

module tb_button_bank_ctrl;

   localparam int NB  = 2;
   localparam int DEB = 4;
   localparam int LP  = 20;
   localparam int RP  = 8;

   logic clk = 1'b0;
   logic rst;

   logic [NB-1:0] btn   [3];
   logic [NB-1:0] lvl   [3];
   logic [NB-1:0] prs   [3];
   logic [NB-1:0] rel   [3];
   logic [NB-1:0] clk_o [3];
   logic [NB-1:0] lng   [3];
   logic [NB-1:0] rpt   [3];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int coincide = 0;

   int c_press [3][NB];
   int c_rel   [3][NB];
   int c_click [3][NB];
   int c_long  [3][NB];
   int c_rep   [3][NB];
   int t_press [3][NB];
   int t_rel   [3][NB];
   int t_click [3][NB];
   int t_long  [3][NB];
   int t_rep1  [3][NB];
   int t_rep2  [3][NB];

   int t0;

   always #5 clk = ~clk;

   button_bank_ctrl #(
      .N_BTN(NB), .DEBOUNCE(DEB), .LONG_PRESS(LP), .REPEAT(RP),
      .REPEAT_EN(1), .ACTIVE_LOW(0), .CNT_W(16)
   ) u_dut0 (
      .i_clk(clk), .i_reset(rst), .i_button(btn[0]),
      .o_level(lvl[0]), .o_press(prs[0]), .o_release(rel[0]),
      .o_click(clk_o[0]), .o_long(lng[0]), .o_repeat(rpt[0])
   );

   button_bank_ctrl #(
      .N_BTN(NB), .DEBOUNCE(DEB), .LONG_PRESS(LP), .REPEAT(RP),
      .REPEAT_EN(0), .ACTIVE_LOW(0), .CNT_W(16)
   ) u_dut1 (
      .i_clk(clk), .i_reset(rst), .i_button(btn[1]),
      .o_level(lvl[1]), .o_press(prs[1]), .o_release(rel[1]),
      .o_click(clk_o[1]), .o_long(lng[1]), .o_repeat(rpt[1])
   );

   button_bank_ctrl #(
      .N_BTN(NB), .DEBOUNCE(DEB), .LONG_PRESS(LP), .REPEAT(RP),
      .REPEAT_EN(1), .ACTIVE_LOW(1), .CNT_W(16)
   ) u_dut2 (
      .i_clk(clk), .i_reset(rst), .i_button(btn[2]),
      .o_level(lvl[2]), .o_press(prs[2]), .o_release(rel[2]),
      .o_click(clk_o[2]), .o_long(lng[2]), .o_repeat(rpt[2])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr_counts();
      for (int d = 0; d < 3; d++) begin
         for (int c = 0; c < NB; c++) begin
            c_press[d][c] = 0; c_rel[d][c] = 0; c_click[d][c] = 0;
            c_long[d][c]  = 0; c_rep[d][c] = 0;
            t_press[d][c] = -1; t_rel[d][c] = -1; t_click[d][c] = -1;
            t_long[d][c]  = -1; t_rep1[d][c] = -1; t_rep2[d][c] = -1;
         end
      end
   endtask

   // Advance n clock edges, sampling 1 ns after each rising edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < NB; c++) begin
               if (prs[d][c] === 1'b1) begin c_press[d][c]++; t_press[d][c] = cyc; end
               if (rel[d][c] === 1'b1) begin c_rel[d][c]++; t_rel[d][c] = cyc; end
               if (clk_o[d][c] === 1'b1) begin c_click[d][c]++; t_click[d][c] = cyc; end
               if (lng[d][c] === 1'b1) begin c_long[d][c]++; t_long[d][c] = cyc; end
               if (rpt[d][c] === 1'b1) begin
                  c_rep[d][c]++;
                  if (c_rep[d][c] == 1) t_rep1[d][c] = cyc;
                  if (c_rep[d][c] == 2) t_rep2[d][c] = cyc;
               end
               if (prs[d][c] === 1'b1 && rel[d][c] === 1'b1) coincide++;
            end
         end
      end
   endtask

   initial begin
      rst    = 1'b1;
      btn[0] = '0;
      btn[1] = '0;
      btn[2] = '1;   // active-low pins idle high
      clr_counts();
      step(3);

      // Reset state
      chk("reset_outputs_dut0", {lvl[0], prs[0], rel[0], clk_o[0], lng[0], rpt[0]}, 0);
      chk("reset_outputs_dut1", {lvl[1], prs[1], rel[1], clk_o[1], lng[1], rpt[1]}, 0);
      chk("reset_outputs_dut2", {lvl[2], prs[2], rel[2], clk_o[2], lng[2], rpt[2]}, 0);

      rst = 1'b0;
      step(12);
      chk("active_low_idle_pulses",
          c_press[2][0] + c_press[2][1] + c_rel[2][0] + c_rel[2][1] + c_long[2][0] + c_long[2][1], 0);
      chk("active_low_idle_level", lvl[2], 0);

      // Clean press of ch0, held 10 cycles, then clean release
      clr_counts();
      t0 = cyc;
      btn[0][0] = 1'b1;
      step(5);
      chk("clean_no_early_press", c_press[0][0], 0);
      step(3);
      chk("clean_level_high", lvl[0][0], 1);
      step(2);
      chk("clean_press_count", c_press[0][0], 1);
      chk("clean_press_latency", t_press[0][0] - t0, 6);
      t0 = cyc;
      btn[0][0] = 1'b0;
      step(10);
      chk("clean_release_count", c_rel[0][0], 1);
      chk("clean_release_latency", t_rel[0][0] - t0, 6);
      chk("clean_click_count", c_click[0][0], 1);
      chk("clean_click_latency", t_click[0][0] - t0, 6);
      chk("clean_no_long", c_long[0][0], 0);
      chk("clean_level_low", lvl[0][0], 0);
      chk("clean_ch1_quiet", c_press[0][1] + c_rel[0][1] + c_click[0][1] + c_long[0][1] + c_rep[0][1], 0);

      // Bounce: high 3, low 1, high 10
      clr_counts();
      btn[0][0] = 1'b1;
      step(3);
      btn[0][0] = 1'b0;
      step(1);
      t0 = cyc;
      btn[0][0] = 1'b1;
      step(10);
      chk("bounce_press_count", c_press[0][0], 1);
      chk("bounce_press_latency", t_press[0][0] - t0, 6);
      btn[0][0] = 1'b0;
      step(10);
      chk("bounce_release_count", c_rel[0][0], 1);

      // Long hold of ch1 for 50 cycles with repeat enabled
      clr_counts();
      t0 = cyc;
      btn[0][1] = 1'b1;
      step(50);
      chk("hold_press_latency", t_press[0][1] - t0, 6);
      chk("hold_long_count", c_long[0][1], 1);
      chk("hold_long_after_press", t_long[0][1] - t_press[0][1], LP);
      chk("hold_rep1_after_long", t_rep1[0][1] - t_long[0][1], RP);
      chk("hold_rep2_after_long", t_rep2[0][1] - t_long[0][1], 2 * RP);
      t0 = cyc;
      btn[0][1] = 1'b0;
      step(10);
      // Repeats at press+28, +36 and +44 all fall before the pin release is seen.
      chk("hold_rep_count", c_rep[0][1], 3);
      chk("hold_release_count", c_rel[0][1], 1);
      chk("hold_release_latency", t_rel[0][1] - t0, 6);
      chk("hold_no_click", c_click[0][1], 0);
      chk("hold_ch0_quiet", c_press[0][0] + c_rel[0][0] + c_long[0][0], 0);

      // Same hold with auto-repeat disabled
      clr_counts();
      btn[1][0] = 1'b1;
      step(50);
      btn[1][0] = 1'b0;
      step(10);
      chk("norep_long_count", c_long[1][0], 1);
      chk("norep_long_after_press", t_long[1][0] - t_press[1][0], LP);
      chk("norep_repeat_count", c_rep[1][0], 0);
      chk("norep_release_count", c_rel[1][0], 1);
      chk("norep_no_click", c_click[1][0], 0);

      // Active-low pin driven low
      clr_counts();
      t0 = cyc;
      btn[2][0] = 1'b0;
      step(10);
      chk("active_low_press_count", c_press[2][0], 1);
      chk("active_low_press_latency", t_press[2][0] - t0, 6);
      chk("active_low_level", lvl[2][0], 1);
      btn[2][0] = 1'b1;
      step(10);
      chk("active_low_click_count", c_click[2][0], 1);

      // Reset while ch0 is held
      clr_counts();
      btn[0][0] = 1'b1;
      step(10);
      chk("rst_mid_level_before", lvl[0][0], 1);
      clr_counts();
      rst = 1'b1;
      #1;
      chk("rst_mid_level_async", lvl[0][0], 0);
      step(2);
      rst = 1'b0;
      t0 = cyc;
      step(10);
      chk("rst_mid_no_release", c_rel[0][0], 0);
      chk("rst_mid_no_click", c_click[0][0], 0);
      chk("rst_mid_repress_count", c_press[0][0], 1);
      chk("rst_mid_repress_latency", t_press[0][0] - t0, 6);
      btn[0][0] = 1'b0;
      step(10);

      chk("press_release_never_coincide", coincide, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
